// File: rtl/extresp.sv
// extresp: external-bus responder serving cache block/doubleword reads and partial/block writes from a doubleword RAM.
// Build option: define EXTRESP_WAIT_EN to insert WAIT phi2 periods before the first read beat.
module extresp #(
  parameter int unsigned AW       = 12,
  parameter string       INITFILE = "",
  parameter int unsigned WAIT     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        phi2,
  input  logic        extreq,
  input  logic        extwr,
  input  logic [4:0]  extsz,
  input  logic [31:0] extaddr,
  input  logic [63:0] extwdata,
  input  logic        extsrc,
  output logic        extrdy,
  output logic        extreply,
  output logic        extreplyto,
  output logic [63:0] extrdata,
  output logic        exterror
);

  typedef enum logic [3:0] {
    IDLE,
`ifdef EXTRESP_WAIT_EN
    WAITST,
`endif
    R0, R1, R2, R3,
    W1, W2, W3
  } state_t;

  if (WAIT > 255) begin : g_wait_chk
    $error("extresp: WAIT must fit the 8-bit wait counter");
  end

  state_t        state_q, state_d;
  logic [AW-1:0] word_q, word_d;
  logic          src_q, src_d;
  logic          oob_q, oob_d;
  logic          blk_q, blk_d;
`ifdef EXTRESP_WAIT_EN
  logic [7:0]    wcnt_q, wcnt_d;
`endif

  logic [63:0]   mem [2**AW];

  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wbe;
  logic [63:0]   wmask;

  logic [AW-1:0] req_word;
  logic          req_oob;
  logic          req_blk;
  logic [3:0]    pw_n;
  logic [3:0]    pw_end;
  logic          pw_ok;
  logic [7:0]    pw_be;

  logic          in_rd;
  logic [1:0]    beat;
  logic [AW-1:0] rd_idx;

  initial begin
    mem = '{default: '0};
  end

  assign req_word = extaddr[AW+2:3];
  assign req_oob  = |extaddr[31:AW+3];
  assign req_blk  = (extsz == 5'd31);

  // wbe[7] is byte 0 (bits 63:56); n ones from the top, shifted down by the byte offset
  assign pw_n   = {1'b0, extsz[2:0]} + 4'd1;
  assign pw_end = {1'b0, extaddr[2:0]} + pw_n;
  assign pw_ok  = (extsz[4:3] == 2'b00) && (pw_end <= 4'd8);
  assign pw_be  = (8'hFF << (4'd8 - pw_n)) >> extaddr[2:0];

  always_comb begin
    in_rd = 1'b0;
    beat  = 2'd0;
    unique case (state_q)
      R0:      begin in_rd = 1'b1; beat = 2'd0; end
      R1:      begin in_rd = 1'b1; beat = 2'd1; end
      R2:      begin in_rd = 1'b1; beat = 2'd2; end
      R3:      begin in_rd = 1'b1; beat = 2'd3; end
      default: ;
    endcase
  end

  // Doubleword reads toggle only bit 0 so the pair stays within the 16-byte line
  assign rd_idx = blk_q ? (word_q + AW'(beat)) : (word_q ^ AW'(beat[0]));

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    src_d   = src_q;
    oob_d   = oob_q;
    blk_d   = blk_q;
`ifdef EXTRESP_WAIT_EN
    wcnt_d  = wcnt_q;
`endif
    we      = 1'b0;
    waddr   = word_q;
    wbe     = '0;
    if (phi2) begin
      unique case (state_q)
        IDLE: begin
          if (extreq) begin
            word_d = req_word;
            src_d  = extsrc;
            oob_d  = req_oob;
            blk_d  = req_blk;
            waddr  = req_word;
            if (!extwr) begin
              state_d = R0;
`ifdef EXTRESP_WAIT_EN
              if (WAIT != 0) begin
                state_d = WAITST;
                wcnt_d  = 8'(WAIT - 1);
              end
`endif
            end else if (req_blk) begin
              state_d = W1;
              we      = !req_oob;
              wbe     = '1;
            end else begin
              we  = !req_oob && pw_ok;
              wbe = pw_be;
            end
          end
        end
`ifdef EXTRESP_WAIT_EN
        WAITST: begin
          if (wcnt_q == '0) state_d = R0;
          else wcnt_d = wcnt_q - 8'd1;
        end
`endif
        R0: state_d = R1;
        R1: state_d = blk_q ? R2 : IDLE;
        R2: state_d = R3;
        R3: state_d = IDLE;
        W1: begin
          state_d = W2;
          we      = !oob_q;
          waddr   = word_q + AW'(1);
          wbe     = '1;
        end
        W2: begin
          state_d = W3;
          we      = !oob_q;
          waddr   = word_q + AW'(2);
          wbe     = '1;
        end
        W3: begin
          state_d = IDLE;
          we      = !oob_q;
          waddr   = word_q + AW'(3);
          wbe     = '1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      src_q   <= 1'b0;
      oob_q   <= 1'b0;
      blk_q   <= 1'b0;
`ifdef EXTRESP_WAIT_EN
      wcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      src_q   <= src_d;
      oob_q   <= oob_d;
      blk_q   <= blk_d;
`ifdef EXTRESP_WAIT_EN
      wcnt_q  <= wcnt_d;
`endif
    end
  end

  assign wmask = {{8{wbe[7]}}, {8{wbe[6]}}, {8{wbe[5]}}, {8{wbe[4]}},
                  {8{wbe[3]}}, {8{wbe[2]}}, {8{wbe[1]}}, {8{wbe[0]}}};

  // RAM is not reset; gating on reset stops an aborted block write from landing
  always_ff @(posedge clk) begin
    if (reset && we) mem[waddr] <= (mem[waddr] & ~wmask) | (extwdata & wmask);
  end

  assign extrdy     = reset && (state_q == IDLE);
  assign extreply   = reset && in_rd;
  assign extreplyto = reset && src_q;
  assign exterror   = reset && in_rd && oob_q;
  assign extrdata   = (reset && in_rd && !oob_q) ? mem[rd_idx] : '0;

endmodule
